// File: rtl/bus_route_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_route_arbiter
// Description : Round-robin arbiter that shares one busSwitch command port
//               between R requesters. It validates each route command, forwards
//               legal ones to the switch one at a time, and remembers which
//               requester owns each in-flight route so it can pulse req_done
//               back to that requester when the switch reports completion.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_route_arbiter #(
    parameter int N       = 1,
    parameter int R       = 2,
    parameter int MAX_OUT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [R*2*N-1:0]   req_cmd,
    input  logic [R-1:0]       req_isReady,
    output logic [R-1:0]       req_canReceive,
    output logic [R-1:0]       req_done,
    output logic [2*N-1:0]     sw_cmd,
    output logic               sw_cmd_isReady,
    input  logic               sw_cmd_canReceive,
    input  logic               sw_done,
    output logic               err_badCmd,
    output logic               err_spurDone,
    output logic               busy
);

    localparam int C_IDW = (R > 1) ? $clog2(R) : 1;
    localparam int C_OW  = $clog2(MAX_OUT + 1);
    localparam int C_PW  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int C_CW  = 2 * N;

    localparam logic [C_OW-1:0]  C_MAX_OUT   = C_OW'(MAX_OUT);
    localparam logic [C_IDW-1:0] C_LAST_ID   = C_IDW'(R - 1);
    localparam logic [C_PW-1:0]  C_LAST_SLOT = C_PW'(MAX_OUT - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    // Registered state
    state_t             state_q;
    logic [C_IDW-1:0]   rr_ptr_q;
    logic [C_IDW-1:0]   issue_id_q;
    logic [C_CW-1:0]    sw_cmd_q;
    logic               sw_cmd_isReady_q;
    logic               err_badCmd_q;
    logic [C_OW-1:0]    outstanding_q;
    logic [C_OW-1:0]    outstanding_d;
    logic [C_IDW-1:0]   fifo_q [MAX_OUT];
    logic [C_PW-1:0]    wr_ptr_q;
    logic [C_PW-1:0]    rd_ptr_q;
    logic [R-1:0]       req_done_q;
    logic               err_spurDone_q;

    // Combinational helpers
    logic               w_win_found;
    logic [C_IDW-1:0]   w_win_idx;
    logic [C_IDW-1:0]   w_probe;
    logic [C_CW-1:0]    w_sel_cmd;
    logic [N-1:0]       w_from;
    logic [N-1:0]       w_to;
    logic               w_legal;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic               w_spur;

    function automatic logic [C_PW-1:0] next_slot(input logic [C_PW-1:0] p);
        return (p == C_LAST_SLOT) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [C_IDW-1:0] next_id(input logic [C_IDW-1:0] id);
        return (id == C_LAST_ID) ? '0 : id + 1'b1;
    endfunction

    // Round-robin search: the lowest offset from rr_ptr with a ready requester
    // wins, so probing from the far end down lets the nearest one overwrite.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_probe     = '0;
        for (int k = R - 1; k >= 0; k--) begin
            w_probe = C_IDW'((int'(rr_ptr_q) + k) % R);
            if (req_isReady[w_probe]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_probe;
            end
        end
    end

    assign w_sel_cmd = req_cmd[w_win_idx * C_CW +: C_CW];
    assign w_from    = w_sel_cmd[N-1:0];
    assign w_to      = w_sel_cmd[C_CW-1:N];
    assign w_legal   = $onehot(w_from) && (w_to != '0);

    // Acceptance looks at this cycle's count only; a same-cycle completion
    // frees a slot starting next cycle.
    assign w_accept = (state_q == S_IDLE) && w_win_found && (outstanding_q < C_MAX_OUT);
    assign w_push   = (state_q == S_ISSUE) && sw_cmd_canReceive;
    assign w_pop    = sw_done && (outstanding_q != '0);
    assign w_spur   = sw_done && (outstanding_q == '0);

    // Grant goes only to the round-robin winner, and never while reset is high
    always_comb begin
        req_canReceive = '0;
        if (w_accept && !rst) begin
            req_canReceive[w_win_idx] = 1'b1;
        end
    end

    // In-flight count: simultaneous push and pop cancel out
    always_comb begin
        outstanding_d = outstanding_q;
        if (w_push && !w_pop) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (!w_push && w_pop) begin
            outstanding_d = outstanding_q - 1'b1;
        end
    end

    // Arbitration FSM: accept/validate in IDLE, hold the command in ISSUE until the switch takes it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= S_IDLE;
            rr_ptr_q         <= '0;
            issue_id_q       <= '0;
            sw_cmd_q         <= '0;
            sw_cmd_isReady_q <= 1'b0;
            err_badCmd_q     <= 1'b0;
        end else begin
            err_badCmd_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_accept) begin
                        rr_ptr_q <= next_id(w_win_idx);
                        if (w_legal) begin
                            sw_cmd_q         <= w_sel_cmd;
                            issue_id_q       <= w_win_idx;
                            sw_cmd_isReady_q <= 1'b1;
                            state_q          <= S_ISSUE;
                        end else begin
                            // Illegal route is consumed and dropped; sw_cmd keeps its last value
                            err_badCmd_q <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (w_push) begin
                        sw_cmd_isReady_q <= 1'b0;
                        state_q          <= S_IDLE;
                    end
                end
                default: begin
                    sw_cmd_isReady_q <= 1'b0;
                    state_q          <= S_IDLE;
                end
            endcase
        end
    end

    // Completion tracking: owner-ID FIFO in issue order, popped on each switch completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding_q  <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            req_done_q     <= '0;
            err_spurDone_q <= 1'b0;
            for (int i = 0; i < MAX_OUT; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            req_done_q     <= '0;
            err_spurDone_q <= w_spur;
            outstanding_q  <= outstanding_d;
            if (w_pop) begin
                req_done_q[fifo_q[rd_ptr_q]] <= 1'b1;
                rd_ptr_q                     <= next_slot(rd_ptr_q);
            end
            if (w_push) begin
                fifo_q[wr_ptr_q] <= issue_id_q;
                wr_ptr_q         <= next_slot(wr_ptr_q);
            end
        end
    end

    assign sw_cmd         = sw_cmd_q;
    assign sw_cmd_isReady = sw_cmd_isReady_q;
    assign req_done       = req_done_q;
    assign err_badCmd     = err_badCmd_q;
    assign err_spurDone   = err_spurDone_q;
    assign busy           = (state_q != S_IDLE) || (outstanding_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_bus_route_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_route_arbiter
// Description : Self-checking bench for bus_route_arbiter (N=4, R=2, MAX_OUT=2)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_route_arbiter;

    localparam int N       = 4;
    localparam int R       = 2;
    localparam int MAX_OUT = 2;
    localparam int CW      = 2 * N;

    logic            clk;
    logic            rst;
    logic [R*CW-1:0] req_cmd;
    logic [R-1:0]    req_isReady;
    logic [R-1:0]    req_canReceive;
    logic [R-1:0]    req_done;
    logic [CW-1:0]   sw_cmd;
    logic            sw_cmd_isReady;
    logic            sw_cmd_canReceive;
    logic            sw_done;
    logic            err_badCmd;
    logic            err_spurDone;
    logic            busy;

    bus_route_arbiter #(.N(N), .R(R), .MAX_OUT(MAX_OUT)) dut (
        .clk               (clk),
        .rst               (rst),
        .req_cmd           (req_cmd),
        .req_isReady       (req_isReady),
        .req_canReceive    (req_canReceive),
        .req_done          (req_done),
        .sw_cmd            (sw_cmd),
        .sw_cmd_isReady    (sw_cmd_isReady),
        .sw_cmd_canReceive (sw_cmd_canReceive),
        .sw_done           (sw_done),
        .err_badCmd        (err_badCmd),
        .err_spurDone      (err_spurDone),
        .busy              (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    bit          m_issuing;
    logic [7:0]  m_swcmd;
    int          m_id;
    int          m_rr;
    int          m_q[$];
    logic [1:0]  m_done;
    bit          m_bad;
    bit          m_spur;

    task automatic model_reset();
        m_issuing = 1'b0;
        m_swcmd   = '0;
        m_id      = 0;
        m_rr      = 0;
        m_q.delete();
        m_done    = '0;
        m_bad     = 1'b0;
        m_spur    = 1'b0;
    endtask

    function automatic bit legal(input logic [7:0] c);
        return ($countones(c[3:0]) == 1) && (c[7:4] != 4'b0);
    endfunction

    // Samples of DUT outputs from the most recent tick
    logic [1:0] s_can, s_done;
    logic       s_sri, s_bad, s_spur, s_busy;
    logic [7:0] s_swcmd;

    // One clock: sample at negedge, compare to model, advance model, return just after posedge
    task automatic tick();
        int         win;
        int         h;
        logic [1:0] e_can;
        logic [7:0] c;
        @(negedge clk);
        s_can   = req_canReceive;
        s_done  = req_done;
        s_sri   = sw_cmd_isReady;
        s_swcmd = sw_cmd;
        s_bad   = err_badCmd;
        s_spur  = err_spurDone;
        s_busy  = busy;
        win = -1;
        if (!m_issuing && m_q.size() < MAX_OUT) begin
            for (int k = 0; k < R; k++) begin
                if (win < 0 && req_isReady[(m_rr + k) % R]) win = (m_rr + k) % R;
            end
        end
        e_can = '0;
        if (win >= 0) e_can[win] = 1'b1;
        chk("model req_canReceive", 32'(s_can), 32'(e_can));
        chk("model sw_cmd_isReady", 32'(s_sri), 32'(m_issuing));
        chk("model sw_cmd", 32'(s_swcmd), 32'(m_swcmd));
        chk("model req_done", 32'(s_done), 32'(m_done));
        chk("model err_badCmd", 32'(s_bad), 32'(m_bad));
        chk("model err_spurDone", 32'(s_spur), 32'(m_spur));
        chk("model busy", 32'(s_busy), 32'(m_issuing || m_q.size() != 0));
        m_done = '0;
        m_bad  = 1'b0;
        m_spur = 1'b0;
        if (sw_done) begin
            if (m_q.size() > 0) begin
                h = m_q.pop_front();
                m_done[h] = 1'b1;
            end else begin
                m_spur = 1'b1;
            end
        end
        if (m_issuing) begin
            if (sw_cmd_canReceive) begin
                m_q.push_back(m_id);
                m_issuing = 1'b0;
            end
        end else if (win >= 0) begin
            c    = req_cmd[win*CW +: CW];
            m_rr = (win + 1) % R;
            if (legal(c)) begin
                m_issuing = 1'b1;
                m_swcmd   = c;
                m_id      = win;
            end else begin
                m_bad = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rand_cmd();
        logic [3:0] f;
        logic [3:0] t;
        if ($urandom_range(0, 4) == 0) return 8'($urandom);
        f = 4'b0001 << $urandom_range(0, 3);
        t = 4'($urandom_range(1, 15));
        return {t, f};
    endfunction

    // ---------------- directed vectors ----------------
    typedef struct packed {
        logic [1:0] rdy;
        logic [7:0] c0;
        logic [7:0] c1;
        logic       swc;
        logic       done;
        logic [1:0] e_can;
        logic       e_sri;
        logic [7:0] e_swcmd;
        logic [1:0] e_done;
        logic       e_bad;
        logic       e_spur;
        logic       e_busy;
    } vec_t;

    vec_t vecs[16];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_g;
        int n_grants;

        //           rdy    c0     c1     swc   done  e_can e_sri e_swcmd e_done bad   spur  busy
        vecs[ 0] = '{2'b01, 8'h41, 8'h00, 1'b1, 1'b0, 2'b01, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[ 1] = '{2'b00, 8'h41, 8'h00, 1'b1, 1'b0, 2'b00, 1'b1, 8'h41, 2'b00, 1'b0, 1'b0, 1'b1};
        vecs[ 2] = '{2'b00, 8'h41, 8'h00, 1'b1, 1'b1, 2'b00, 1'b0, 8'h41, 2'b00, 1'b0, 1'b0, 1'b1};
        vecs[ 3] = '{2'b00, 8'h41, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0, 8'h41, 2'b01, 1'b0, 1'b0, 1'b0};
        vecs[ 4] = '{2'b10, 8'h41, 8'h13, 1'b1, 1'b0, 2'b10, 1'b0, 8'h41, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[ 5] = '{2'b01, 8'h22, 8'h13, 1'b1, 1'b0, 2'b01, 1'b0, 8'h41, 2'b00, 1'b1, 1'b0, 1'b0};
        vecs[ 6] = '{2'b00, 8'h22, 8'h13, 1'b0, 1'b0, 2'b00, 1'b1, 8'h22, 2'b00, 1'b0, 1'b0, 1'b1};
        vecs[ 7] = '{2'b10, 8'h22, 8'h84, 1'b1, 1'b0, 2'b00, 1'b1, 8'h22, 2'b00, 1'b0, 1'b0, 1'b1};
        vecs[ 8] = '{2'b10, 8'h22, 8'h84, 1'b1, 1'b0, 2'b10, 1'b0, 8'h22, 2'b00, 1'b0, 1'b0, 1'b1};
        vecs[ 9] = '{2'b00, 8'h22, 8'h84, 1'b1, 1'b1, 2'b00, 1'b1, 8'h84, 2'b00, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{2'b00, 8'h22, 8'h84, 1'b1, 1'b0, 2'b00, 1'b0, 8'h84, 2'b01, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{2'b00, 8'h22, 8'h84, 1'b1, 1'b1, 2'b00, 1'b0, 8'h84, 2'b00, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{2'b00, 8'h22, 8'h84, 1'b1, 1'b0, 2'b00, 1'b0, 8'h84, 2'b10, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{2'b00, 8'h22, 8'h84, 1'b1, 1'b1, 2'b00, 1'b0, 8'h84, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{2'b00, 8'h22, 8'h84, 1'b1, 1'b0, 2'b00, 1'b0, 8'h84, 2'b00, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{2'b00, 8'h22, 8'h84, 1'b1, 1'b0, 2'b00, 1'b0, 8'h84, 2'b00, 1'b0, 1'b0, 1'b0};

        // Reset state, with requests pending to show grants are held off
        rst               = 1'b1;
        req_cmd           = {8'h82, 8'h11};
        req_isReady       = 2'b11;
        sw_cmd_canReceive = 1'b1;
        sw_done           = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset req_canReceive", 32'(req_canReceive), 32'h0);
        chk("reset sw_cmd", 32'(sw_cmd), 32'h0);
        chk("reset sw_cmd_isReady", 32'(sw_cmd_isReady), 32'h0);
        chk("reset req_done", 32'(req_done), 32'h0);
        chk("reset err_badCmd", 32'(err_badCmd), 32'h0);
        chk("reset err_spurDone", 32'(err_spurDone), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        req_isReady = 2'b00;
        rst         = 1'b0;

        // Basic route, illegal command, coincident push/pop, spurious done
        for (int v = 0; v < 16; v++) begin
            req_isReady       = vecs[v].rdy;
            req_cmd           = {vecs[v].c1, vecs[v].c0};
            sw_cmd_canReceive = vecs[v].swc;
            sw_done           = vecs[v].done;
            tick();
            chk($sformatf("vec%0d can", v),    32'(s_can),   32'(vecs[v].e_can));
            chk($sformatf("vec%0d sri", v),    32'(s_sri),   32'(vecs[v].e_sri));
            chk($sformatf("vec%0d swcmd", v),  32'(s_swcmd), 32'(vecs[v].e_swcmd));
            chk($sformatf("vec%0d done", v),   32'(s_done),  32'(vecs[v].e_done));
            chk($sformatf("vec%0d bad", v),    32'(s_bad),   32'(vecs[v].e_bad));
            chk($sformatf("vec%0d spur", v),   32'(s_spur),  32'(vecs[v].e_spur));
            chk($sformatf("vec%0d busy", v),   32'(s_busy),  32'(vecs[v].e_busy));
        end

        // Both requesters hold continuously, instant completion: grants alternate
        req_cmd           = {8'h82, 8'h11};
        req_isReady       = 2'b11;
        sw_cmd_canReceive = 1'b1;
        sw_done           = 1'b0;
        exp_g             = 0;
        n_grants          = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (s_can != 2'b00) begin
                chk("rr grant order", 32'(s_can), 32'(2'b01 << exp_g));
                exp_g = 1 - exp_g;
                n_grants++;
            end
            sw_done = s_sri;
        end
        chk("rr grant count", 32'(n_grants), 32'd4);
        req_isReady = 2'b00;
        tick();
        sw_done = 1'b0;
        tick();

        // Outstanding limit: two issued, third blocked until a completion lands
        req_isReady = 2'b01;
        repeat (4) tick();
        tick();
        chk("maxout blocks grant", 32'(s_can), 32'h0);
        chk("maxout busy", 32'(s_busy), 32'h1);
        sw_done = 1'b1;
        tick();
        chk("same-cycle pop still blocked", 32'(s_can), 32'h0);
        sw_done = 1'b0;
        tick();
        chk("third granted", 32'(s_can), 32'h1);
        chk("first completion owner", 32'(s_done), 32'h1);

        // Reset while issuing with one route in flight
        sw_cmd_canReceive = 1'b0;
        #1;
        chk("pre-reset issuing", 32'(sw_cmd_isReady), 32'h1);
        chk("pre-reset busy", 32'(busy), 32'h1);
        #1;
        rst = 1'b1;
        #1;
        chk("async reset canReceive", 32'(req_canReceive), 32'h0);
        chk("async reset sw_cmd_isReady", 32'(sw_cmd_isReady), 32'h0);
        chk("async reset sw_cmd", 32'(sw_cmd), 32'h0);
        chk("async reset busy", 32'(busy), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst         = 1'b0;
        req_isReady = 2'b00;
        sw_done     = 1'b1;
        tick();
        sw_done = 1'b0;
        tick();
        chk("post-reset done is spurious", 32'(s_spur), 32'h1);
        chk("post-reset no req_done", 32'(s_done), 32'h0);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if (c % 700 == 699) begin
                rst         = 1'b1;
                req_isReady = 2'b00;
                sw_done     = 1'b0;
                model_reset();
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
            for (int i = 0; i < R; i++) begin
                if (!req_isReady[i] && $urandom_range(0, 1) == 1) begin
                    req_cmd[i*CW +: CW] = rand_cmd();
                    req_isReady[i]      = 1'b1;
                end
            end
            sw_cmd_canReceive = ($urandom_range(0, 9) < 7);
            sw_done           = ($urandom_range(0, 9) < 4);
            tick();
            for (int i = 0; i < R; i++) begin
                if (s_can[i] && req_isReady[i]) req_isReady[i] = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
